seq_signed_divider: RTL and testbench



---
 rtl/seq_signed_divider.sv | 136 +++++++++++++
 tb/tb_seq_signed_divider.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// Sequential signed restoring divider: one quotient bit per clock, start/done handshake.
// Magnitudes are divided unsigned, then signs are restored in a final fix-up cycle.
module seq_signed_divider #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic           sq_q, sq_d;
  logic           sr_q, sr_d;
  logic           dz_q, dz_d;
  logic [N-1:0]   dmag_q, dmag_d;
  logic [N-1:0]   qreg_q, qreg_d;
  logic [N:0]     prem_q, prem_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;

  logic [N:0]     rem_shift;
  logic [N:0]     rem_trial;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      dz_q        <= 1'b0;
      dmag_q      <= '0;
      qreg_q      <= '0;
      prem_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sq_q        <= sq_d;
      sr_q        <= sr_d;
      dz_q        <= dz_d;
      dmag_q      <= dmag_d;
      qreg_q      <= qreg_d;
      prem_q      <= prem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sq_d        = sq_q;
    sr_d        = sr_q;
    dz_d        = dz_q;
    dmag_d      = dmag_q;
    qreg_d      = qreg_q;
    prem_d      = prem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;

    rem_shift = {prem_q[N-1:0], qreg_q[N-1]};
    rem_trial = rem_shift - {1'b0, dmag_q};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sq_d    = dividend[N-1] ^ divisor[N-1];
          sr_d    = dividend[N-1];
          qreg_d  = dividend[N-1] ? -dividend : dividend;
          dmag_d  = divisor[N-1] ? -divisor : divisor;
          prem_d  = '0;
          count_d = CW'(N);
          dbz_d   = 1'b0;
          dz_d    = (divisor == '0);
          // A zero divisor skips the iterations and resolves in the fix-up cycle.
          state_d = (divisor == '0) ? StFix : StIter;
        end
      end
      StIter: begin
        if (!rem_trial[N]) begin
          prem_d = rem_trial;
          qreg_d = {qreg_q[N-2:0], 1'b1};
        end else begin
          prem_d = rem_shift;
          qreg_d = {qreg_q[N-2:0], 1'b0};
        end
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (dz_q) begin
          // qreg still holds |dividend|, so re-applying its sign recovers the raw dividend.
          quotient_d  = '1;
          remainder_d = sr_q ? -qreg_q : qreg_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = sq_q ? -qreg_q : qreg_q;
          remainder_d = sr_q ? -prem_q[N-1:0] : prem_q[N-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed testbench for seq_signed_divider (N=8): vector table plus handshake/reset sequences.
module tb_seq_signed_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_signed_divider #(.N(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[10];

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%02h expected=0x%02h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic checki(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges after the accept edge until done is seen; 40 means it never came.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (done) break;
    end
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
    vecs[1] = '{8'h9C,  8'd7,   8'hF2,  8'hFE,  1'b0};
    vecs[2] = '{8'd100, 8'hF9,  8'hF2,  8'd2,   1'b0};
    vecs[3] = '{8'h9C,  8'hF9,  8'd14,  8'hFE,  1'b0};
    vecs[4] = '{8'h80,  8'hFF,  8'h80,  8'h00,  1'b0};
    vecs[5] = '{8'h80,  8'h01,  8'h80,  8'h00,  1'b0};
    vecs[6] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    vecs[7] = '{8'd127, 8'd1,   8'd127, 8'd0,   1'b0};
    vecs[8] = '{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1};
    vecs[9] = '{8'hFB,  8'd0,   8'hFF,  8'hFB,  1'b1};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    rst = 1'b0;
    check8("reset_q", quotient, 8'h00);
    check8("reset_r", remainder, 8'h00);
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_dbz", div_by_zero, 1'b0);

    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].a, vecs[i].b);
      check1($sformatf("v%0d_busy", i), busy, 1'b1);
      check1($sformatf("v%0d_dbz_clr", i), div_by_zero, 1'b0);
      wait_done(lat);
      checki($sformatf("v%0d_lat", i), lat, vecs[i].dz ? 1 : 9);
      check8($sformatf("v%0d_q", i), quotient, vecs[i].q);
      check8($sformatf("v%0d_r", i), remainder, vecs[i].r);
      check1($sformatf("v%0d_dz", i), div_by_zero, vecs[i].dz);
      check1($sformatf("v%0d_busy_end", i), busy, 1'b0);
      tick();
      check1($sformatf("v%0d_done_pulse", i), done, 1'b0);
      check8($sformatf("v%0d_q_hold", i), quotient, vecs[i].q);
    end

    // start pulsed at edge k+3 while busy must be ignored
    launch(8'd100, 8'd7);
    tick(); tick();
    dividend = 8'd50; divisor = 8'd3; start = 1'b1;
    tick();
    start = 1'b0; dividend = 8'd100; divisor = 8'd7;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      tick();
      lat++;
    end
    checki("ign_lat", lat + 3, 9);
    check8("ign_q", quotient, 8'd14);
    check8("ign_r", remainder, 8'd2);
    tick();
    check1("ign_no_second_done", done, 1'b0);
    check1("ign_idle", busy, 1'b0);

    // back-to-back: start asserted during the done cycle is accepted
    launch(8'd100, 8'd7);
    wait_done(lat);
    checki("b2b_lat1", lat, 9);
    check8("b2b_q1", quotient, 8'd14);
    dividend = 8'd50; divisor = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check1("b2b_accept_busy", busy, 1'b1);
    check1("b2b_done_low", done, 1'b0);
    check8("b2b_q_hold", quotient, 8'd14);
    wait_done(lat);
    checki("b2b_lat2", lat, 9);
    check8("b2b_q2", quotient, 8'd16);
    check8("b2b_r2", remainder, 8'd2);

    // reset at edge k+4 abandons the operation
    tick();
    launch(8'd100, 8'd7);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check8("rst_q", quotient, 8'h00);
    check8("rst_r", remainder, 8'h00);
    check1("rst_busy", busy, 1'b0);
    check1("rst_dbz", div_by_zero, 1'b0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen++;
      tick();
    end
    checki("rst_no_done", seen, 0);
    launch(8'd9, 8'd2);
    wait_done(lat);
    checki("post_rst_lat", lat, 9);
    check8("post_rst_q", quotient, 8'd4);
    check8("post_rst_r", remainder, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
